jpeg_dct_sequencer: RTL and testbench
=====================================

Name: jpeg_dct_sequencer

Overview:
- Central sequencer for the JPEG accelerator's 2-D DCT path: input block RAM, 8-point DCT, transpose memory, quantizer and output block RAM.
- On a start request it runs one 8x8 block through the path:
  - row pass: inmem -> DCT -> transpose
  - column pass: transpose -> DCT -> quantizer -> utmem
- It generates every enable, select and address from one clock. The DCT and transpose run on a clock-enable strobe, not a divided clock.
- It sits between the DMA/Wishbone control logic (start/busy/done) and the datapath.

Parameters:
- SLOT_CYC, 4, clock cycles per DCT slot. One dct_ce pulse per slot. Legal range 4..16. Values outside the range are an elaboration error.
- DCT_LAT, 4, number of dct_ce pulses from DCT input to DCT output. Legal range 1..8.

Ports:
- clk_i, input, 1, system clock (wb.clk)
- rst_ni, input, 1, asynchronous active-low reset
- start_i, input, 1, start one block; sampled only when idle
- clr_i, input, 1, synchronous abort; returns to IDLE and clears err_o
- busy_o, output, 1, block in progress
- done_o, output, 1, one-cycle pulse at block completion
- err_o, output, 1, sticky: start_i seen while busy
- in_rd_en_o, output, 1, inmem read enable
- in_addr_o, output, 4, inmem word address (16 words of 4 pixels)
- in_ld_lo_o, output, 1, latch inmem data as pixels 0-3 of the row
- in_ld_hi_o, output, 1, latch inmem data as pixels 4-7 of the row
- dct_ce_o, output, 1, DCT and transpose clock enable
- mux1_o, output, 1, DCT input select: 0 = inmem row, 1 = transpose output
- tw_en_o, output, 1, transpose write enable (level)
- tr_en_o, output, 1, transpose read enable (level)
- out_sel_o, output, 2, selects coefficient pair (2c, 2c+1) of the DCT output for the quantizer
- rec_idx_o, output, 6, reciprocal table index of the first coefficient of the pair
- ut_we_o, output, 1, utmem write enable
- ut_addr_o, output, 5, utmem word address

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous and active-low; asserting it mid-block aborts immediately with no done_o.
- All outputs are registered. Each value stated below is present during the stated cycle.
- Timing notation:
  - Cycle t = 0 is the first cycle after start_i is sampled high in IDLE.
  - Slot s spans cycles s*SLOT_CYC .. s*SLOT_CYC + SLOT_CYC - 1.
  - p is the cycle index within the slot.
- States and transitions:
  - IDLE -> RUN on start_i.
  - RUN -> DONE after the last slot.
  - DONE -> IDLE after one cycle.
- busy_o is 1 for t = 0 .. 24*SLOT_CYC - 1.
- dct_ce_o: 1 at p = SLOT_CYC-1 of every slot s = 0 .. 15+DCT_LAT. Exactly 16+DCT_LAT pulses.
- Row input, slots s = r in 0..7:
  - p=0: in_rd_en_o=1, in_addr_o=2r.
  - p=1: in_rd_en_o=1, in_addr_o=2r+1, in_ld_lo_o=1.
  - p=2: in_ld_hi_o=1.
  - mux1_o=0 for the whole slot.
- tw_en_o is 1 for slots DCT_LAT .. DCT_LAT+7.
- Column input, slots 8+DCT_LAT .. 15+DCT_LAT: tr_en_o=1, mux1_o=1.
- mux1_o returns to 0 at the first slot after the column input slots.
- Output writes, slots k = 0..7 at slot 8+2*DCT_LAT+k, for p = c in 0..3:
  - ut_we_o=1
  - out_sel_o=c
  - ut_addr_o=4k+c
  - rec_idx_o=8k+2c
- The quantizer uses rec_idx_o and rec_idx_o+1.
- Last slot is 15+2*DCT_LAT. With default parameters this is slot 23 and done_o is at t=96.
- The busy_o / done_o equations above (24*SLOT_CYC) assume the default DCT_LAT=4. In general:
  - busy_o ends at (16+2*DCT_LAT)*SLOT_CYC - 1.
  - done_o pulses at (16+2*DCT_LAT)*SLOT_CYC, together with busy_o falling to 0.
- ut_addr_o wraps 31 -> 0 only through the return to IDLE; it is never driven above 31.
- start_i while busy: ignored, err_o set to 1 (sticky). start_i in the done_o cycle also counts as while busy.
- clr_i: next cycle is IDLE, all outputs 0, err_o 0, no done_o.
  - clr_i and start_i together: clr_i wins and start_i is dropped.
- start_i in IDLE on the cycle after done_o is accepted (back-to-back blocks, 1 idle cycle).

Test Plan:
- Default params, start_i one cycle → busy_o high cycles 0..95, done_o pulse at t=96, 24 dct_ce_o pulses at t=3,7,...,95.
- Default params, log the inmem interface → in_addr_o sequence 0,1,...,15, with in_ld_lo_o at t=4r+1 and in_ld_hi_o at t=4r+2; tw_en_o high t=16..47; tr_en_o and mux1_o high t=48..79.
- Default params, log utmem writes → 32 writes at t=64..95; ut_addr_o 0..31 in order; rec_idx_o = 0,2,4,6,8,...,62; out_sel_o cycling 0,1,2,3.
- start_i again at t=40 → ignored, err_o=1 from t=41 and remaining set until clr_i. The block completes normally at t=96.
- clr_i at t=50 together with start_i → all outputs 0 at t=51, no done_o, err_o=0. A new start at t=60 runs a full block.
- SLOT_CYC=6, DCT_LAT=2: done_o at t=120; dct_ce_o at p=5 of slots 0..17; ut writes at slots 12..19, p=0..3.
- Drop rst_ni at t=30 → all outputs 0 asynchronously. After release, IDLE and no done_o.

Source files
------------

// File: rtl/jpeg_dct_sequencer.sv
// Sequencer for the 2-D DCT path: one 8x8 block per start, row pass then column pass.
// Every enable, select and address is registered and decoded from a slot/phase counter pair.
module jpeg_dct_sequencer #(
    parameter int unsigned SLOT_CYC = 4,
    parameter int unsigned DCT_LAT  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       clr_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       in_rd_en_o,
    output logic [3:0] in_addr_o,
    output logic       in_ld_lo_o,
    output logic       in_ld_hi_o,
    output logic       dct_ce_o,
    output logic       mux1_o,
    output logic       tw_en_o,
    output logic       tr_en_o,
    output logic [1:0] out_sel_o,
    output logic [5:0] rec_idx_o,
    output logic       ut_we_o,
    output logic [4:0] ut_addr_o
);

    localparam int unsigned SLOT_W    = 5;
    localparam int unsigned PH_W      = 4;
    localparam int unsigned NUM_SLOTS = 16 + 2 * DCT_LAT;

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] ROW_END   = SLOT_W'(8);
    localparam logic [SLOT_W-1:0] TW_FIRST  = SLOT_W'(DCT_LAT);
    localparam logic [SLOT_W-1:0] TW_LAST   = SLOT_W'(DCT_LAT + 7);
    localparam logic [SLOT_W-1:0] COL_FIRST = SLOT_W'(8 + DCT_LAT);
    localparam logic [SLOT_W-1:0] COL_LAST  = SLOT_W'(15 + DCT_LAT);
    localparam logic [SLOT_W-1:0] OUT_FIRST = SLOT_W'(8 + 2 * DCT_LAT);

    if (SLOT_CYC < 4 || SLOT_CYC > 16) begin : g_bad_slot_cyc
        $error("jpeg_dct_sequencer: SLOT_CYC must be in 4..16");
    end
    if (DCT_LAT < 1 || DCT_LAT > 8) begin : g_bad_dct_lat
        $error("jpeg_dct_sequencer: DCT_LAT must be in 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              err_q, err_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       in_rd_en_q, in_rd_en_d;
    logic [3:0] in_addr_q, in_addr_d;
    logic       in_ld_lo_q, in_ld_lo_d;
    logic       in_ld_hi_q, in_ld_hi_d;
    logic       dct_ce_q, dct_ce_d;
    logic       mux1_q, mux1_d;
    logic       tw_en_q, tw_en_d;
    logic       tr_en_q, tr_en_d;
    logic [1:0] out_sel_q, out_sel_d;
    logic [5:0] rec_idx_q, rec_idx_d;
    logic       ut_we_q, ut_we_d;
    logic [4:0] ut_addr_q, ut_addr_d;
    logic [2:0] out_k;

    // Next state, then outputs decoded from the next slot/phase so they register in step.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        err_d      = err_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        in_rd_en_d = 1'b0;
        in_addr_d  = 4'd0;
        in_ld_lo_d = 1'b0;
        in_ld_hi_d = 1'b0;
        dct_ce_d   = 1'b0;
        mux1_d     = 1'b0;
        tw_en_d    = 1'b0;
        tr_en_d    = 1'b0;
        out_sel_d  = 2'd0;
        rec_idx_d  = 6'd0;
        ut_we_d    = 1'b0;
        ut_addr_d  = 5'd0;
        out_k      = 3'd0;

        if (clr_i) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            phase_d = '0;
            err_d   = 1'b0;
        end else begin
            if (start_i && state_q != ST_IDLE) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                        slot_d  = '0;
                        phase_d = '0;
                    end
                end
                ST_RUN: begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (slot_q == SLOT_LAST) begin
                            state_d = ST_DONE;
                            slot_d  = '0;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        done_d = (state_d == ST_DONE);
        if (state_d == ST_RUN) begin
            busy_d   = 1'b1;
            dct_ce_d = (phase_d == PH_LAST) && (slot_d <= COL_LAST);
            tw_en_d  = (slot_d >= TW_FIRST) && (slot_d <= TW_LAST);
            tr_en_d  = (slot_d >= COL_FIRST) && (slot_d <= COL_LAST);
            mux1_d   = tr_en_d;
            // Two inmem words per row: low half at p=0, high half at p=1, latched one cycle later.
            if (slot_d < ROW_END) begin
                in_rd_en_d = (phase_d < PH_W'(2));
                in_addr_d  = in_rd_en_d ? {slot_d[2:0], phase_d[0]} : 4'd0;
                in_ld_lo_d = (phase_d == PH_W'(1));
                in_ld_hi_d = (phase_d == PH_W'(2));
            end
            // Four coefficient pairs written per output slot.
            if (slot_d >= OUT_FIRST && phase_d < PH_W'(4)) begin
                out_k     = 3'(slot_d - OUT_FIRST);
                ut_we_d   = 1'b1;
                out_sel_d = phase_d[1:0];
                ut_addr_d = {out_k, phase_d[1:0]};
                rec_idx_d = {out_k, phase_d[1:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            phase_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_rd_en_q <= 1'b0;
            in_addr_q  <= 4'd0;
            in_ld_lo_q <= 1'b0;
            in_ld_hi_q <= 1'b0;
            dct_ce_q   <= 1'b0;
            mux1_q     <= 1'b0;
            tw_en_q    <= 1'b0;
            tr_en_q    <= 1'b0;
            out_sel_q  <= 2'd0;
            rec_idx_q  <= 6'd0;
            ut_we_q    <= 1'b0;
            ut_addr_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_rd_en_q <= in_rd_en_d;
            in_addr_q  <= in_addr_d;
            in_ld_lo_q <= in_ld_lo_d;
            in_ld_hi_q <= in_ld_hi_d;
            dct_ce_q   <= dct_ce_d;
            mux1_q     <= mux1_d;
            tw_en_q    <= tw_en_d;
            tr_en_q    <= tr_en_d;
            out_sel_q  <= out_sel_d;
            rec_idx_q  <= rec_idx_d;
            ut_we_q    <= ut_we_d;
            ut_addr_q  <= ut_addr_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign in_rd_en_o = in_rd_en_q;
    assign in_addr_o  = in_addr_q;
    assign in_ld_lo_o = in_ld_lo_q;
    assign in_ld_hi_o = in_ld_hi_q;
    assign dct_ce_o   = dct_ce_q;
    assign mux1_o     = mux1_q;
    assign tw_en_o    = tw_en_q;
    assign tr_en_o    = tr_en_q;
    assign out_sel_o  = out_sel_q;
    assign rec_idx_o  = rec_idx_q;
    assign ut_we_o    = ut_we_q;
    assign ut_addr_o  = ut_addr_q;

endmodule

// File: tb/tb_jpeg_dct_sequencer.sv
// Scoreboard bench: default instance (4,4) and a (6,2) instance against a timeline model.
module tb_jpeg_dct_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       rd;
        logic [3:0] addr;
        logic       ld_lo;
        logic       ld_hi;
        logic       ce;
        logic       mux1;
        logic       tw;
        logic       tr;
        logic [1:0] sel;
        logic [5:0] rec;
        logic       we;
        logic [4:0] uaddr;
    } ovec_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] sel;
        logic [5:0] rec;
    } ut_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] clr_v;
    ovec_t      out_a;
    ovec_t      out_b;

    ovec_t exp_qa[$];
    ovec_t exp_qb[$];
    ut_t   ut_qa[$];
    ut_t   ut_qb[$];
    ovec_t ev_a, ev_b;
    ut_t   uw_a, uw_b;

    int   mt[2];
    logic merr[2];
    int   checks;
    int   errors;

    jpeg_dct_sequencer #(.SLOT_CYC(4), .DCT_LAT(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[0]), .clr_i(clr_v[0]),
        .busy_o(out_a.busy), .done_o(out_a.done), .err_o(out_a.err),
        .in_rd_en_o(out_a.rd), .in_addr_o(out_a.addr),
        .in_ld_lo_o(out_a.ld_lo), .in_ld_hi_o(out_a.ld_hi),
        .dct_ce_o(out_a.ce), .mux1_o(out_a.mux1), .tw_en_o(out_a.tw), .tr_en_o(out_a.tr),
        .out_sel_o(out_a.sel), .rec_idx_o(out_a.rec), .ut_we_o(out_a.we), .ut_addr_o(out_a.uaddr)
    );

    jpeg_dct_sequencer #(.SLOT_CYC(6), .DCT_LAT(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[1]), .clr_i(clr_v[1]),
        .busy_o(out_b.busy), .done_o(out_b.done), .err_o(out_b.err),
        .in_rd_en_o(out_b.rd), .in_addr_o(out_b.addr),
        .in_ld_lo_o(out_b.ld_lo), .in_ld_hi_o(out_b.ld_hi),
        .dct_ce_o(out_b.ce), .mux1_o(out_b.mux1), .tw_en_o(out_b.tw), .tr_en_o(out_b.tr),
        .out_sel_o(out_b.sel), .rec_idx_o(out_b.rec), .ut_we_o(out_b.we), .ut_addr_o(out_b.uaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sc_of(input int d);
        return (d == 0) ? 4 : 6;
    endfunction

    function automatic int lt_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int total_of(input int d);
        return (16 + 2 * lt_of(d)) * sc_of(d);
    endfunction

    // Expected outputs at cycle t of a block (t<0: idle), from the slot timeline.
    function automatic ovec_t exp_vec(input int t, input int d, input logic e);
        ovec_t v;
        int sc, l, s, p, k;
        v     = '0;
        v.err = e;
        if (t < 0) return v;
        if (t == total_of(d)) begin
            v.done = 1'b1;
            return v;
        end
        sc     = sc_of(d);
        l      = lt_of(d);
        s      = t / sc;
        p      = t % sc;
        v.busy = 1'b1;
        v.ce   = (p == sc - 1) && (s <= 15 + l);
        v.tw   = (s >= l) && (s <= l + 7);
        v.tr   = (s >= 8 + l) && (s <= 15 + l);
        v.mux1 = v.tr;
        if (s < 8) begin
            v.rd    = (p < 2);
            v.addr  = v.rd ? 4'(2 * s + p) : 4'd0;
            v.ld_lo = (p == 1);
            v.ld_hi = (p == 2);
        end
        k = s - (8 + 2 * l);
        if (k >= 0 && k < 8 && p < 4) begin
            v.we    = 1'b1;
            v.sel   = 2'(p);
            v.uaddr = 5'(4 * k + p);
            v.rec   = 6'(8 * k + 2 * p);
        end
        return v;
    endfunction

    // Address/select/index only carry meaning while their enable is expected.
    function automatic ovec_t mask_vec(input ovec_t v, input ovec_t e);
        ovec_t m;
        m = v;
        if (!e.rd) m.addr = 4'd0;
        if (!e.we) begin
            m.sel   = 2'd0;
            m.rec   = 6'd0;
            m.uaddr = 5'd0;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    task automatic push_writes(input int d);
        ut_t u;
        for (int n = 0; n < 32; n++) begin
            u.addr = 5'(n);
            u.sel  = 2'(n % 4);
            u.rec  = 6'(2 * n);
            if (d == 0) ut_qa.push_back(u);
            else        ut_qb.push_back(u);
        end
    endtask

    task automatic model_step(input int d, input logic s, input logic c);
        if (c) begin
            mt[d]   = -1;
            merr[d] = 1'b0;
            if (d == 0) ut_qa.delete();
            else        ut_qb.delete();
        end else if (mt[d] < 0) begin
            if (s) begin
                mt[d] = 0;
                push_writes(d);
            end
        end else begin
            if (s) merr[d] = 1'b1;
            if (mt[d] == total_of(d)) begin
                mt[d] = -1;
                if (d == 0) chk("ut_count_a", 32'(ut_qa.size()), 32'd0);
                else        chk("ut_count_b", 32'(ut_qb.size()), 32'd0);
            end else begin
                mt[d] = mt[d] + 1;
            end
        end
        if (d == 0) exp_qa.push_back(exp_vec(mt[0], 0, merr[0]));
        else        exp_qb.push_back(exp_vec(mt[1], 1, merr[1]));
    endtask

    task automatic cycle(input logic sa, input logic ca, input logic sb, input logic cb);
        @(negedge clk);
        #1;
        start_v = {sb, sa};
        clr_v   = {cb, ca};
        model_step(0, sa, ca);
        model_step(1, sb, cb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (mt[d] >= 0 && n < 500) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        start_v = 2'b00;
        clr_v   = 2'b00;
        #1;
        chk("rst_async_a", 32'(out_a), 32'd0);
        chk("rst_async_b", 32'(out_b), 32'd0);
        exp_qa.delete();
        exp_qb.delete();
        ut_qa.delete();
        ut_qb.delete();
        mt[0] = -1;
        mt[1] = -1;
        merr[0] = 1'b0;
        merr[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle output monitor and utmem write scoreboard.
    always @(negedge clk) begin
        if (exp_qa.size() > 0) begin
            ev_a = exp_qa.pop_front();
            chk("vec_a", 32'(mask_vec(out_a, ev_a)), 32'(mask_vec(ev_a, ev_a)));
        end
        if (exp_qb.size() > 0) begin
            ev_b = exp_qb.pop_front();
            chk("vec_b", 32'(mask_vec(out_b, ev_b)), 32'(mask_vec(ev_b, ev_b)));
        end
        if (rst_n && out_a.we) begin
            if (ut_qa.size() == 0) chk("ut_extra_a", 32'(out_a.we), 32'd0);
            else begin
                uw_a = ut_qa.pop_front();
                chk("ut_write_a", 32'({out_a.uaddr, out_a.sel, out_a.rec}), 32'(uw_a));
            end
        end
        if (rst_n && out_b.we) begin
            if (ut_qb.size() == 0) chk("ut_extra_b", 32'(out_b.we), 32'd0);
            else begin
                uw_b = ut_qb.pop_front();
                chk("ut_write_b", 32'({out_b.uaddr, out_b.sel, out_b.rec}), 32'(uw_b));
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start_v = 2'b00;
        clr_v   = 2'b00;
        mt[0]   = -1;
        mt[1]   = -1;
        merr[0] = 1'b0;
        merr[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_a", 32'(out_a), 32'd0);
        chk("reset_b", 32'(out_b), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Full block, then back-to-back start one cycle after done.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        idle(2);

        // Start while busy at t=40 sets sticky err; cleared by clr in idle.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(40);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // clr together with start at t=50, then a new block at t=60.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(50);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(9);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        idle(2);

        // Second parameter set; a start in its done cycle counts as busy.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(120);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Random start/clr traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 199) == 0));
        end
        wait_idle(0);
        wait_idle(1);
        idle(2);

        // Asynchronous reset 30 cycles into a block.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(30);
        mid_reset();
        idle(20);

        chk("ut_drain_a", 32'(ut_qa.size()), 32'd0);
        chk("ut_drain_b", 32'(ut_qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
